leds_sched: RTL and testbench
=============================

// Module: leds_sched
// PURPOSE
//  Time-slot scheduler that shares the 8-bit LED port (LPORT) between NREQ requesters.
//  Each requester raises req with an 8-bit pattern. The winner's pattern drives LPORT for SLOT_CYCLES clocks.
//  Arbitration is round-robin. Sits between application blocks and the board LED pins.
// PARAMETERS
//  NREQ          4            number of requesters (2..8)
//  SLOT_CYCLES   12_000_000   clocks per slot (1 s at 12 MHz); must be >= 1
//  IDLE_PATTERN  8'h00        LPORT value when no slot is active
//  TW            $clog2(SLOT_CYCLES+1)   slot timer width (derived, localparam)
// PORTS
//  clk      in   1       system clock
//  rstn     in   1       asynchronous active-low reset
//  req      in   NREQ    slot request, level, one bit per requester
//  pattern  in   NREQ*8  LED pattern; requester i uses bits [8i+7:8i]
//  gnt      out  NREQ    one-hot, high for the whole slot of the owner
//  done     out  NREQ    one-cycle pulse on the last cycle of the owner's slot
//  busy     out  1       a slot is active
//  LPORT    out  8       LED port
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; gnt=0, done=0, busy=0, LPORT=IDLE_PATTERN; rr pointer=NREQ-1, so req[0] wins first.
//  States: IDLE, SHOW.
//  IDLE:
//   - If any req is high, pick a winner w by round-robin: first set bit searching from pointer+1 modulo NREQ.
//   - Register gnt=1<<w, LPORT=pattern[w], timer=SLOT_CYCLES-1, pointer=w; go to SHOW.
//   - Latency: req edge -> gnt/LPORT valid on the next clock edge (1 cycle).
//  SHOW:
//   - While timer!=0, decrement. LPORT holds the latched pattern; pattern changes mid-slot are ignored.
//   - When timer==0 (last cycle): done[w]=1 for this one cycle.
//   - On that same edge, re-arbitrate over the current req. If a winner exists, start its slot back-to-back (no idle cycle); else go to IDLE.
//   - Back-to-back slots: gnt switches directly from one one-hot value to the next, and LPORT switches to the new pattern.
//  Withdrawal: req dropped mid-slot does not shorten the slot; done still pulses.
//  Re-request: the owner still requesting at slot end wins again only if no other req is set (round-robin fairness).
//  SLOT_CYCLES=1: every slot lasts one cycle; done coincides with gnt on each granted cycle.
//  busy = (state==SHOW). gnt, done, busy and LPORT are all registered outputs.
//  Reset mid-slot: everything returns to reset values immediately; no done pulse is issued.
// CONFIGURATION
//  LEDS_SCHED_PRIO_EN defined:
//   - Requester 0 has strict priority. It wins any arbitration where req[0]=1, regardless of the pointer.
//   - The pointer is not updated when requester 0 wins.
//   - It never preempts an active slot.
//  Not defined: pure round-robin as described above.
// STRUCTURE
//  Package leds_sched_pkg: state encoding (ST_IDLE=1'b0, ST_SHOW=1'b1) and LED_W=8.
//  Sub-module leds_rr_pick: combinational round-robin pick.
//   - Inputs: req and pointer. Outputs: valid and winner index.
//   - Takes a PRIO parameter driven from LEDS_SCHED_PRIO_EN.
//  Top level: FSM, slot timer, pattern latch and output registers.
// TESTING (NREQ=4, SLOT_CYCLES=4, IDLE_PATTERN=8'h00)
//  1. Reset, no req -> LPORT=8'h00, gnt=0, busy=0 indefinitely.
//  2. req=0001, pattern0=8'hAA -> gnt=0001 next cycle, LPORT=8'hAA for 4 cycles, done[0] on the 4th; req dropped -> IDLE, LPORT=8'h00.
//  3. req=1111 held, patterns 11/22/44/88 -> LPORT cycles 11,22,44,88,11... with 4 cycles each and no gaps; each done pulses once per slot.
//  4. Change pattern1 from 8'h22 to 8'hFF mid-slot 1 -> LPORT stays 8'h22 until slot end.
//  5. Assert rstn=0 in cycle 2 of a slot -> gnt/busy/LPORT reset asynchronously; no done; after release req[0] wins first.
//  6. LEDS_SCHED_PRIO_EN defined, req=1111 held -> requester 0 wins every slot. Undefined -> order 0,1,2,3.

Source files
------------

// File: rtl/leds_sched_pkg.sv
// Shared definitions for the LED time-slot scheduler.
//   ST_IDLE / ST_SHOW : FSM state encoding
//   LED_W             : width of the LED port and of each requester pattern
package leds_sched_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SHOW = 1'b1;

  localparam int LED_W = 8;

endpackage

// File: rtl/leds_rr_pick.sv
// Combinational round-robin pick for the LED scheduler.
//   req    in   NREQ   request vector
//   ptr    in   PW     index of the last winner; search starts at ptr+1
//   valid  out  1      at least one request is set
//   win    out  PW     winner index (don't-care when valid=0)
// PRIO=1 gives requester 0 strict priority whenever req[0] is set.
module leds_rr_pick #(
  parameter int NREQ = 4,
  parameter bit PRIO = 1'b0,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   win
);

  int idx;

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // the pointer is the one left standing; avoids a loop break.
  always_comb begin
    valid = |req;
    win   = '0;
    idx   = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) win = PW'(idx);
    end
    if (PRIO && req[0]) win = '0;
  end

endmodule

// File: rtl/leds_sched.sv
// Time-slot scheduler sharing the 8-bit LED port between NREQ requesters.
// The round-robin winner's pattern is latched and shown on LPORT for
// SLOT_CYCLES clocks; slots run back-to-back while requests are pending.
//   clk      in   1         system clock
//   rstn     in   1         asynchronous active-low reset
//   req      in   NREQ      level slot request per requester
//   pattern  in   NREQ*8    requester i pattern at [8i+7:8i]
//   gnt      out  NREQ      one-hot owner of the active slot
//   done     out  NREQ      pulse on the last cycle of the owner's slot
//   busy     out  1         a slot is active
//   LPORT    out  8         LED port
// Optional macro LEDS_SCHED_PRIO_EN: requester 0 gets strict priority at
// arbitration (never preempts) and its wins leave the pointer untouched.
module leds_sched
  import leds_sched_pkg::*;
#(
  parameter int           NREQ         = 4,
  parameter int           SLOT_CYCLES  = 12_000_000,
  parameter logic [7:0]   IDLE_PATTERN = 8'h00
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pattern,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [LED_W-1:0]      LPORT
);

  localparam int TW = $clog2(SLOT_CYCLES + 1);
  localparam int PW = $clog2(NREQ);
  localparam logic [TW-1:0] T_LOAD = TW'(SLOT_CYCLES - 1);
  localparam bit ONE_CYC = (SLOT_CYCLES == 1);

`ifdef LEDS_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              state;
  logic [TW-1:0]     timer;
  logic [PW-1:0]     ptr;
  logic              pick_vld;
  logic [PW-1:0]     pick_win;
  logic [NREQ-1:0]   win_oh;
  logic [LED_W-1:0]  win_pat;
  logic              arb;
  logic              keep_ptr;

  leds_rr_pick #(.NREQ(NREQ), .PRIO(PRIO)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .win   (pick_win)
  );

  assign win_oh   = {{(NREQ-1){1'b0}}, 1'b1} << pick_win;
  assign win_pat  = pattern[pick_win*LED_W +: LED_W];
  // Arbitrate when idle or on the last cycle of a slot (timer==0).
  assign arb      = (state == ST_IDLE) || (timer == '0);
  // A priority win by requester 0 must not disturb round-robin order.
  assign keep_ptr = PRIO && req[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      timer <= '0;
      ptr   <= PW'(NREQ - 1);
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      LPORT <= IDLE_PATTERN;
    end else if (arb) begin
      if (pick_vld) begin
        state <= ST_SHOW;
        busy  <= 1'b1;
        timer <= T_LOAD;
        gnt   <= win_oh;
        LPORT <= win_pat;
        // A one-cycle slot is its own last cycle.
        done  <= ONE_CYC ? win_oh : '0;
        if (!keep_ptr) ptr <= pick_win;
      end else begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        timer <= '0;
        gnt   <= '0;
        done  <= '0;
        LPORT <= IDLE_PATTERN;
      end
    end else begin
      timer <= timer - 1'b1;
      // done is registered, so raise it on the edge entering timer==0.
      done  <= (timer == TW'(1)) ? gnt : '0;
    end
  end

endmodule

// File: tb/tb_leds_sched.sv
// Self-checking bench for leds_sched: directed vector tables, a mid-slot
// reset sequence, and a randomized run against a slot-level reference model
// for SLOT_CYCLES=4 and SLOT_CYCLES=1 instances.
module tb_leds_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] pattern = '0;

  logic [3:0]  gnt0, done0, gnt1, done1;
  logic        busy0, busy1;
  logic [7:0]  lp0, lp1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  leds_sched #(.NREQ(4), .SLOT_CYCLES(4), .IDLE_PATTERN(8'h00)) u0 (
    .clk(clk), .rstn(rstn), .req(req), .pattern(pattern),
    .gnt(gnt0), .done(done0), .busy(busy0), .LPORT(lp0));

  leds_sched #(.NREQ(4), .SLOT_CYCLES(1), .IDLE_PATTERN(8'h00)) u1 (
    .clk(clk), .rstn(rstn), .req(req), .pattern(pattern),
    .gnt(gnt1), .done(done1), .busy(busy1), .LPORT(lp1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (slot-level) ----------------
  // Each instance is described by its owner, how many cycles of the slot
  // have elapsed, the last round-robin winner and the latched pattern.
  int          slot_len [2] = '{4, 1};
  int          m_own [2];
  int          m_cnt [2];
  int          m_ptr [2];
  logic [7:0]  m_pat [2];

  function automatic int pick(input logic [3:0] r, input int p, output bit upd);
    upd = 1'b1;
`ifdef LEDS_SCHED_PRIO_EN
    if (r[0]) begin
      upd = 1'b0;
      return 0;
    end
`endif
    for (int i = 1; i <= 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int w;
    bit upd;
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k] = -1; m_cnt[k] = 0; m_ptr[k] = 3; m_pat[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_own[k] < 0 || m_cnt[k] == slot_len[k]) begin
          w = pick(req, m_ptr[k], upd);
          if (w >= 0) begin
            m_own[k] = w;
            m_cnt[k] = 1;
            m_pat[k] = pattern[8*w +: 8];
            if (upd) m_ptr[k] = w;
          end else begin
            m_own[k] = -1;
            m_cnt[k] = 0;
          end
        end else begin
          m_cnt[k]++;
        end
      end
    end
  end

  task automatic check_model(input int cyc);
    logic [3:0] eg, ed;
    logic       eb;
    logic [7:0] el;
    for (int k = 0; k < 2; k++) begin
      eb = (m_own[k] >= 0);
      eg = eb ? (4'b0001 << m_own[k]) : 4'b0000;
      ed = (eb && m_cnt[k] == slot_len[k]) ? eg : 4'b0000;
      el = eb ? m_pat[k] : 8'h00;
      if (k == 0) begin
        chk($sformatf("rnd%0d u0.gnt", cyc), gnt0, eg);
        chk($sformatf("rnd%0d u0.done", cyc), done0, ed);
        chk($sformatf("rnd%0d u0.busy", cyc), busy0, eb);
        chk($sformatf("rnd%0d u0.LPORT", cyc), lp0, el);
      end else begin
        chk($sformatf("rnd%0d u1.gnt", cyc), gnt1, eg);
        chk($sformatf("rnd%0d u1.done", cyc), done1, ed);
        chk($sformatf("rnd%0d u1.busy", cyc), busy1, eb);
        chk($sformatf("rnd%0d u1.LPORT", cyc), lp1, el);
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  lp;
  } vec_t;

  function automatic vec_t mk(input bit rs, input logic [3:0] rq, input logic [31:0] pt,
                              input logic [3:0] g, input logic [3:0] d, input logic b,
                              input logic [7:0] l);
    vec_t v;
    v.rst = rs; v.req = rq; v.pat = pt; v.gnt = g; v.done = d; v.busy = b; v.lp = l;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] base;
    int          own;
    logic [3:0]  g;
    bit          prio;

    base = 32'h8844_2211;
`ifdef LEDS_SCHED_PRIO_EN
    prio = 1'b1;
`else
    prio = 1'b0;
`endif

    // Single requester, withdrawn mid-slot: slot still runs 4 cycles.
    tbl.push_back(mk(0, 4'b0001, 32'h0000_00AA, 4'b0001, 4'b0000, 1, 8'hAA));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00AA, 4'b0001, 4'b0000, 1, 8'hAA));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00AA, 4'b0001, 4'b0000, 1, 8'hAA));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00AA, 4'b0001, 4'b0001, 1, 8'hAA));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00AA, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 4'b0000, 32'h0000_00AA, 4'b0000, 4'b0000, 0, 8'h00));
    // All requesting from reset: 11,22,44,88,11 with 4 cycles each; pattern1
    // changed to FF during slot 1 must not show.
    for (int r = 0; r <= 16; r++) begin
      own = prio ? 0 : (r / 4) % 4;
      g   = 4'b0001 << own;
      tbl.push_back(mk(r == 0, 4'b1111, (r >= 5) ? 32'h8844_FF11 : base,
                       g, (r % 4 == 3) ? g : 4'b0000, 1, base[8*own +: 8]));
    end

    // Reset, then idle with no requests.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset gnt", gnt0, 4'b0000);
    chk("reset busy", busy0, 1'b0);
    chk("reset LPORT", lp0, 8'h00);
    chk("reset done", done0, 4'b0000);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d gnt", i), gnt0, 4'b0000);
      chk($sformatf("idle%0d busy", i), busy0, 1'b0);
      chk($sformatf("idle%0d LPORT", i), lp0, 8'h00);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
      end
      req = tbl[i].req;
      pattern = tbl[i].pat;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d gnt", i), gnt0, tbl[i].gnt);
      chk($sformatf("tbl%0d done", i), done0, tbl[i].done);
      chk($sformatf("tbl%0d busy", i), busy0, tbl[i].busy);
      chk($sformatf("tbl%0d LPORT", i), lp0, tbl[i].lp);
    end

    // Reset in cycle 2 of a slot.
    @(negedge clk);
    rstn = 1'b0; #2; rstn = 1'b1;
    req = 4'b0010; pattern = base;
    @(posedge clk); #1;
    chk("mid c1 gnt", gnt0, 4'b0010);
    chk("mid c1 LPORT", lp0, 8'h22);
    @(posedge clk); #1;
    chk("mid c2 gnt", gnt0, 4'b0010);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid rst gnt", gnt0, 4'b0000);
    chk("mid rst busy", busy0, 1'b0);
    chk("mid rst LPORT", lp0, 8'h00);
    chk("mid rst done", done0, 4'b0000);
    @(negedge clk);
    rstn = 1'b1;
    req = 4'b1111;
    @(posedge clk); #1;
    chk("post rst gnt", gnt0, 4'b0001);
    chk("post rst LPORT", lp0, 8'h11);
    chk("post rst done", done0, 4'b0000);

    // Randomized run against the model, both slot lengths.
    @(negedge clk);
    rstn = 1'b0; #1; rstn = 1'b1;
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        rstn = 1'b0; #1; rstn = 1'b1;
      end
      case ($urandom_range(0, 7))
        0, 1: req = 4'($urandom_range(0, 15));
        2:    req = 4'b1111;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) pattern = $urandom;
      @(posedge clk); #1;
      check_model(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
